// File: rtl/vga_timing_gen.sv
// Parametrised VESA-style timing generator: counters, sync, blanking, data enable and line/frame strobes.
// Optional VGA_TIMING_FRAME_CNT_EN adds a 16-bit frame counter output.
module vga_timing_gen #(
  parameter int H_ACTIVE   = 800,
  parameter int H_FP       = 40,
  parameter int H_SYNC     = 128,
  parameter int H_BP       = 88,
  parameter int V_ACTIVE   = 600,
  parameter int V_FP       = 1,
  parameter int V_SYNC     = 4,
  parameter int V_BP       = 23,
  parameter bit H_SYNC_POL = 1'b1,
  parameter bit V_SYNC_POL = 1'b1,
  parameter int CNT_W      = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pix_en,
  input  logic             restart,
  output logic [CNT_W-1:0] hcount,
  output logic [CNT_W-1:0] vcount,
  output logic             hsync,
  output logic             vsync,
  output logic             hblnk,
  output logic             vblnk,
  output logic             de,
  output logic             line_start,
  output logic             frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [15:0]      frame_cnt
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

  logic             adv;
  logic [CNT_W-1:0] nh;
  logic [CNT_W-1:0] nv;
  logic             nhsync;
  logic             nvsync;
  logic             nhblnk;
  logic             nvblnk;
  logic             nline;
  logic             nframe;

  // Next position is decoded before registering so flags never lag the counters.
  always_comb begin
    adv = restart | pix_en;
    nh  = hcount;
    nv  = vcount;
    if (restart) begin
      nh = '0;
      nv = '0;
    end else if (hcount == H_LAST) begin
      nh = '0;
      nv = (vcount == V_LAST) ? '0 : vcount + CNT_W'(1);
    end else begin
      nh = hcount + CNT_W'(1);
    end
    nhblnk = (32'(nh) >= H_ACTIVE);
    nvblnk = (32'(nv) >= V_ACTIVE);
    nhsync = ((32'(nh) >= H_ACTIVE + H_FP) && (32'(nh) < H_ACTIVE + H_FP + H_SYNC))
             ? H_SYNC_POL : !H_SYNC_POL;
    nvsync = ((32'(nv) >= V_ACTIVE + V_FP) && (32'(nv) < V_ACTIVE + V_FP + V_SYNC))
             ? V_SYNC_POL : !V_SYNC_POL;
    nline  = (nh == '0);
    nframe = (nh == '0) && (nv == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcount      <= '0;
      vcount      <= '0;
      hsync       <= !H_SYNC_POL;
      vsync       <= !V_SYNC_POL;
      hblnk       <= 1'b0;
      vblnk       <= 1'b0;
      de          <= 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (adv) begin
      hcount      <= nh;
      vcount      <= nv;
      hsync       <= nhsync;
      vsync       <= nvsync;
      hblnk       <= nhblnk;
      vblnk       <= nvblnk;
      de          <= !nhblnk && !nvblnk;
      line_start  <= nline;
      frame_start <= nframe;
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  // Counts each edge that registers a new frame_start, restarts included.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
    end else if (adv && nframe) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end
`endif

endmodule
